// File: rtl/fetch_pc_pkg.sv
// Shared fetch pipeline definitions: FSM encoding and sequential PC step.
package fetch_pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } fetch_state_e;

    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_if2_reg.sv
// IF2 stage register: PC of the instruction whose cache data returns, plus qualifiers.
module fetch_if2_reg #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  taken_in,
    output logic [ADDR_WIDTH-1:0] pc_if2,
    output logic                  if2_valid,
    output logic                  prd_taken_if2
);

    // clr kills the qualifiers only; pc_if2 is meaningless while if2_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_if2        <= '0;
            if2_valid     <= 1'b0;
            prd_taken_if2 <= 1'b0;
        end else if (clr) begin
            if2_valid     <= 1'b0;
            prd_taken_if2 <= 1'b0;
        end else if (en) begin
            pc_if2        <= pc_in;
            if2_valid     <= 1'b1;
            prd_taken_if2 <= taken_in;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: boot/run/trap sequencing, predictor redirect, IF2 tracking.
module fetch_pc_gen
    import fetch_pc_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cache_ready,
    input  logic                  cache_ready_data,
    input  logic                  prd_valid,
    input  logic [ADDR_WIDTH-1:0] prd_addr,
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_addr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_req,
    output logic [ADDR_WIDTH-1:0] pc_if2,
    output logic                  if2_valid,
    output logic                  prd_taken_if2,
    output logic [31:0]           fetch_count
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] BOOT_PC    = RESET_VECTOR & ALIGN_MASK;

    fetch_state_e          state;
    logic                  advance;
    logic                  run_adv;
    logic [ADDR_WIDTH-1:0] pc_seq;
    logic [ADDR_WIDTH-1:0] pc_next;

    assign advance = cache_ready & cache_ready_data;
    assign run_adv = (state == ST_RUN) & advance & ~trap_valid;
    assign pc_seq  = pc + ADDR_WIDTH'(PC_INC);
    assign pc_next = prd_valid ? (prd_addr & ALIGN_MASK) : pc_seq;

    // BOOT and TRAP each last exactly one cycle whether or not the caches are ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= BOOT_PC;
            pc_req      <= 1'b0;
            fetch_count <= '0;
        end else if (trap_valid) begin
            state  <= ST_TRAP;
            pc     <= trap_addr & ALIGN_MASK;
            pc_req <= 1'b0;
        end else begin
            case (state)
                ST_BOOT, ST_TRAP: begin
                    state  <= ST_RUN;
                    pc_req <= 1'b1;
                end
                ST_RUN: begin
                    if (advance) begin
                        pc          <= pc_next;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: begin
                    state  <= ST_BOOT;
                    pc_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_if2_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_if2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (run_adv),
        .clr          (trap_valid),
        .pc_in        (pc),
        .taken_in     (pc_next != pc_seq),
        .pc_if2       (pc_if2),
        .if2_valid    (if2_valid),
        .prd_taken_if2(prd_taken_if2)
    );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed + randomized bench for fetch_pc_gen against a rule-level fetch model.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cache_ready = 1'b0;
    logic        cache_ready_data = 1'b0;
    logic        prd_valid = 1'b0;
    logic [63:0] prd_addr = '0;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_addr = '0;
    logic [63:0] pc;
    logic        pc_req;
    logic [63:0] pc_if2;
    logic        if2_valid;
    logic        prd_taken_if2;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    // reference model: phase 0=boot 1=run 2=trap
    int          m_phase;
    logic [63:0] m_pc, m_pc_if2;
    logic        m_v, m_tk;
    logic [31:0] m_cnt;

    fetch_pc_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cache_ready     (cache_ready),
        .cache_ready_data(cache_ready_data),
        .prd_valid       (prd_valid),
        .prd_addr        (prd_addr),
        .trap_valid      (trap_valid),
        .trap_addr       (trap_addr),
        .pc              (pc),
        .pc_req          (pc_req),
        .pc_if2          (pc_if2),
        .if2_valid       (if2_valid),
        .prd_taken_if2   (prd_taken_if2),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pc = '0; m_pc_if2 = '0; m_v = 0; m_tk = 0; m_cnt = '0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},     pc, m_pc);
        chk({tag, ".req"},    {63'd0, pc_req}, {63'd0, m_phase == 1});
        chk({tag, ".pc_if2"}, pc_if2, m_pc_if2);
        chk({tag, ".v"},      {63'd0, if2_valid}, {63'd0, m_v});
        chk({tag, ".tk"},     {63'd0, prd_taken_if2}, {63'd0, m_tk});
        chk({tag, ".cnt"},    {32'd0, fetch_count}, {32'd0, m_cnt});
    endtask

    // drive one cycle of inputs at negedge, clock it, advance model, check at next negedge
    task automatic step(input string tag, input logic cr, input logic crd, input logic pv,
                        input logic [63:0] pa, input logic tv, input logic [63:0] ta);
        logic [63:0] nxt;
        cache_ready = cr; cache_ready_data = crd; prd_valid = pv; prd_addr = pa;
        trap_valid = tv; trap_addr = ta;
        @(posedge clk);
        if (tv) begin
            m_pc = ta & ~64'd3; m_v = 0; m_tk = 0; m_phase = 2;
        end else if (m_phase != 1) begin
            m_phase = 1;
        end else if (cr && crd) begin
            nxt = pv ? (pa & ~64'd3) : m_pc + 64'd4;
            m_pc_if2 = m_pc; m_v = 1; m_tk = (nxt != m_pc + 64'd4);
            m_pc = nxt; m_cnt = m_cnt + 1;
        end
        @(negedge clk);
        chk_all(tag);
    endtask

    initial begin
        model_reset();
        // reset and boot sequence
        repeat (2) @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;
        #1 chk_all("boot");
        chk("boot.req0", {63'd0, pc_req}, 64'd0);
        step("boot2run", 1, 1, 0, 0, 0, 0);
        chk("run.pc0", pc, 64'h0);
        step("seq4", 1, 1, 0, 0, 0, 0);
        chk("seq4.pc", pc, 64'h4);
        chk("seq4.if2", {pc_if2[62:0], if2_valid}, {63'h0, 1'b1});
        step("seq8", 1, 1, 0, 0, 0, 0);
        chk("seq8.pc", pc, 64'h8);

        // predicted redirect from 0x100
        step("trap100", 1, 1, 0, 0, 1, 64'h100);
        step("trap100.run", 1, 1, 0, 0, 0, 0);
        step("prd200", 1, 1, 1, 64'h200, 0, 0);
        chk("prd200.pc", pc, 64'h200);
        chk("prd200.if2", pc_if2, 64'h100);
        chk("prd200.tk", {63'd0, prd_taken_if2}, 64'd1);
        step("prd204", 1, 1, 1, 64'h204, 0, 0);
        chk("prd204.tk", {63'd0, prd_taken_if2}, 64'd0);

        // stall at 0x40
        step("trap40", 1, 1, 0, 0, 1, 64'h40);
        step("trap40.run", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 1, 64'h900, 0, 0);
        chk("stall.pc", pc, 64'h40);
        step("resume", 1, 1, 0, 0, 0, 0);
        chk("resume.pc", pc, 64'h44);

        // trap with advance low, unaligned handler address
        step("trap8k", 0, 0, 0, 0, 1, 64'h8000_0003);
        chk("trap8k.pc", pc, 64'h8000_0000);
        chk("trap8k.req", {63'd0, pc_req}, 64'd0);
        step("trap8k.run", 0, 0, 0, 0, 0, 0);
        chk("trap8k.req1", {63'd0, pc_req}, 64'd1);
        step("trap.twice", 1, 1, 0, 0, 1, 64'h300);
        step("trap.again", 1, 1, 0, 0, 1, 64'h500);
        step("trap.again.run", 1, 1, 0, 0, 0, 0);
        step("trap.again.adv", 1, 1, 0, 0, 0, 0);
        chk("trap.again.pc", pc, 64'h504);

        // wrap at top of address space
        step("trapTop", 1, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step("trapTop.run", 1, 1, 0, 0, 0, 0);
        step("wrap", 1, 1, 0, 0, 0, 0);
        chk("wrap.pc", pc, 64'h0);
        chk("wrap.tk", {63'd0, prd_taken_if2}, 64'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [63:0] pa;
            logic [63:0] ta;
            pa = ($urandom_range(0, 2) == 0) ? (m_pc + 64'd4) | 64'($urandom_range(0, 3))
                                              : {$urandom, $urandom};
            ta = {$urandom, $urandom};
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom), pa, $urandom_range(0, 15) == 0, ta);
        end

        // asynchronous reset in the middle of a trap
        step("preRst", 1, 1, 0, 0, 1, 64'h7000);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("asyncRst");
        chk("asyncRst.pc", pc, 64'h0);
        trap_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_all("rst.boot");
        step("rst.run", 1, 1, 0, 0, 0, 0);
        step("rst.adv", 1, 1, 0, 0, 0, 0);
        chk("rst.adv.pc", pc, 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, width of all address ports.
REQ-002 Parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  sole clock, rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 CACHE_READY  in  1  instruction cache ready.
REQ-007 CACHE_READY_DATA  in  1  data cache ready.
REQ-008 PRD_VALID  in  1  predictor next-address valid.
REQ-009 PRD_ADDR  in  ADDR_WIDTH  predictor next fetch address.
REQ-010 TRAP_VALID  in  1  trap/interrupt redirect request.
REQ-011 TRAP_ADDR  in  ADDR_WIDTH  trap handler address.
REQ-012 PC  out  ADDR_WIDTH  current fetch PC, to predictor and I-cache.
REQ-013 PC_REQ  out  1  fetch request valid this cycle.
REQ-014 PC_IF2  out  ADDR_WIDTH  PC of instruction whose cache data returns now.
REQ-015 IF2_VALID  out  1  PC_IF2 qualifies a real instruction.
REQ-016 PRD_TAKEN_IF2  out  1  PC_IF2 was followed by a non-sequential prediction.
REQ-017 FETCH_COUNT  out  32  number of advanced fetches since reset.

Function
REQ-018 advance SHALL equal CACHE_READY & CACHE_READY_DATA; every register SHALL hold when advance is 0, except on trap (REQ-023).
REQ-019 FSM states BOOT, RUN, TRAP; BOOT after reset release, lasting exactly one cycle regardless of advance, then RUN.
REQ-020 In BOOT: PC=RESET_VECTOR, PC_REQ=0, IF2_VALID=0.
REQ-021 In RUN: PC_REQ=1; on advance, next PC = PRD_ADDR if PRD_VALID else PC+4; PC_IF2<=PC; IF2_VALID<=1; PRD_TAKEN_IF2<=(next PC != PC+4).
REQ-022 PC+4 SHALL wrap modulo 2^ADDR_WIDTH; PC[1:0] SHALL always be 00 (low bits of PRD_ADDR/TRAP_ADDR/RESET_VECTOR cleared).
REQ-023 TRAP_VALID SHALL take priority over prediction and advance in any state: PC<=TRAP_ADDR, IF2_VALID<=0, PRD_TAKEN_IF2<=0, state<=TRAP.
REQ-024 TRAP lasts one cycle with PC_REQ=0 and IF2_VALID=0, then RUN; a new TRAP_VALID during TRAP reloads PC and stays in TRAP one more cycle.
REQ-025 TRAP_VALID during BOOT SHALL win: PC<=TRAP_ADDR, state<=TRAP.
REQ-026 FETCH_COUNT SHALL increment by 1 per RUN-state advance, wrapping at 2^32.
REQ-027 Latency: prediction on PRD_ADDR at cycle n with advance appears on PC at n+1; PC at n appears on PC_IF2 at n+1.

Reset
REQ-028 While RST_N=0: PC=RESET_VECTOR (low bits cleared), PC_REQ=0, PC_IF2=0, IF2_VALID=0, PRD_TAKEN_IF2=0, FETCH_COUNT=0, state=BOOT.
REQ-029 Reset assertion mid-stall or mid-trap SHALL discard all state immediately; no redirect survives reset.

Structure
REQ-030 FSM state encoding and the PC increment constant (4) SHALL live in a shared pipeline package.
REQ-031 One sub-module is natural: fetch_if2_reg, holding PC_IF2/IF2_VALID/PRD_TAKEN_IF2 with enable and clear.

Verification
REQ-032 Reset release, advance=1, PRD_VALID=0 -> PC: 0 (BOOT, PC_REQ=0), 0, 4, 8; IF2_VALID first 1 with PC_IF2=0.
REQ-033 RUN at PC=0x100, PRD_VALID=1, PRD_ADDR=0x200 -> next PC=0x200, PC_IF2=0x100, PRD_TAKEN_IF2=1; PRD_ADDR=0x104 -> PRD_TAKEN_IF2=0.
REQ-034 PC=0x40, CACHE_READY_DATA=0 for 3 cycles -> PC, PC_IF2, FETCH_COUNT unchanged; resumes with PC=0x44.
REQ-035 TRAP_VALID=1, TRAP_ADDR=0x8000_0003 with advance=0 -> PC=0x8000_0000, IF2_VALID=0, one cycle PC_REQ=0, then RUN.
REQ-036 PC=0xFFFF_FFFF_FFFF_FFFC, PRD_VALID=0, advance -> PC=0, PRD_TAKEN_IF2=0.
REQ-037 RST_N pulsed low asynchronously mid-TRAP -> outputs at reset values before next CLK edge, BOOT follows release.
